// File: rtl/bus_pkg.sv
// Shared types and address constants for the 68000 bus-cycle controller.
// Latency: n/a (types, constants and pure decode functions only).
// Backpressure: n/a.
package bus_pkg;

   // Decoded target of a CPU bus cycle; RGN_NONE means unmapped.
   typedef enum logic [1:0] {
      RGN_NONE = 2'd0,
      RGN_RAM  = 2'd1,
      RGN_ROM  = 2'd2,
      RGN_IO   = 2'd3
   } region_t;

   // Bus-cycle FSM states.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_ACK  = 2'd2,
      ST_BERR = 2'd3
   } state_t;

   // A23..A20 nibbles of the memory map.
   localparam logic [3:0] RAM_LO  = 4'h0;
   localparam logic [3:0] RAM_HI  = 4'h1;
   localparam logic [3:0] IO_NIB  = 4'hE;
   localparam logic [3:0] ROM_NIB = 4'hF;

   // Region decode in priority order. While boot is low every read goes
   // to ROM so the reset vectors at 0x000000 come from ROM. Writes to the
   // ROM nibble are unmapped and therefore end in a bus error.
   function automatic region_t decode_region(input logic [3:0] addr,
                                             input logic       rw,
                                             input logic       boot);
      region_t r;
      r = RGN_NONE;
      if (!boot && rw) begin
         r = RGN_ROM;
      end else if (addr == RAM_LO || addr == RAM_HI) begin
         r = RGN_RAM;
      end else if (addr == ROM_NIB && rw) begin
         r = RGN_ROM;
      end else if (addr == IO_NIB) begin
         r = RGN_IO;
      end
      return r;
   endfunction

   // Largest of four values; sizes the cycle counters.
   function automatic int max4(input int a, input int b, input int c, input int d);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      if (d > m) m = d;
      return m;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer for asynchronous level inputs.
// Latency: 2 clocks from d to q.
// Backpressure: none; q simply follows d.
module sync_2ff #(
   parameter int   WIDTH   = 1,
   parameter logic RST_VAL = 1'b1
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta;

   // First stage may go metastable; second stage gives it a clock to settle.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         meta <= {WIDTH{RST_VAL}};
         q    <= {WIDTH{RST_VAL}};
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/bus_cycle_controller.sv
// 68000 bus-cycle controller: chip-select decode, per-region wait states, DTACK_n / BERR_n.
// Latency: start 2-3 clocks after AS_n falls; DTACK_n WAIT+1 clocks after start; BERR_n BERR_TIMEOUT clocks after start.
// Backpressure: the CPU stalls on DTACK_n/BERR_n; a new cycle is accepted only after AS_n has been seen high.
module bus_cycle_controller
   import bus_pkg::*;
#(
   parameter int RAM_WAIT     = 1,
   parameter int ROM_WAIT     = 3,
   parameter int IO_WAIT      = 4,
   parameter int BERR_TIMEOUT = 64
) (
   input  logic       CLK,
   input  logic       RESET_n,
   input  logic       AS_n,
   input  logic       RW,
   input  logic [3:0] ADDR,
   input  logic       BOOT,
   output logic       RAM_CS_n,
   output logic       ROM_CS_n,
   output logic       IO_CS_n,
   output logic       DTACK_n,
   output logic       BERR_n
);

   localparam int CW = $clog2(max4(RAM_WAIT, ROM_WAIT, IO_WAIT, BERR_TIMEOUT) + 1);
   localparam logic [CW-1:0] TMO_LAST = CW'(BERR_TIMEOUT - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   // Wait-state count loaded into the wait counter for each region.
   function automatic logic [CW-1:0] wait_of(input region_t r);
      case (r)
         RGN_RAM: return CW'(RAM_WAIT);
         RGN_ROM: return CW'(ROM_WAIT);
         RGN_IO:  return CW'(IO_WAIT);
         default: return '0;
      endcase
   endfunction

   logic          as_s;
   logic [1:0]    sync_fill;
   logic          armed;
   logic          start;
   state_t        state;
   state_t        state_nxt;
   logic [3:0]    addr_l;
   logic          rw_l;
   logic          boot_l;
   logic [CW-1:0] wcnt;
   logic [CW-1:0] tcnt;
   region_t       rgn_start;
   region_t       rgn_cur;
   region_t       rgn_nxt;
   logic          sel_nxt;
   logic          ram_cs_nxt;
   logic          rom_cs_nxt;
   logic          io_cs_nxt;
   logic          dtack_nxt;
   logic          berr_nxt;

   sync_2ff #(
      .WIDTH   (1),
      .RST_VAL (1'b1)
   ) u_as_sync (
      .clk     (CLK),
      .reset_n (RESET_n),
      .d       (AS_n),
      .q       (as_s)
   );

   // ADDR/RW/BOOT are already stable when AS_n is low (the CPU drives them
   // before the strobe and BOOT only moves on AS_n rising), so by the time
   // the synchronized strobe is seen they can be sampled directly.
   assign rgn_start = decode_region(ADDR, RW, BOOT);
   assign rgn_cur   = decode_region(addr_l, rw_l, boot_l);
   assign start     = (state == ST_IDLE) && !as_s && armed;

   // Cycle datapath: arming, start latches, wait and timeout counters.
   always_ff @(posedge CLK) begin
      if (!RESET_n) begin
         sync_fill <= 2'b00;
         armed     <= 1'b0;
         addr_l    <= 4'h0;
         rw_l      <= 1'b0;
         boot_l    <= 1'b0;
         wcnt      <= '0;
         tcnt      <= '0;
      end else begin
         // The synchronizer holds its reset value (high) for two clocks after
         // reset; only a high that really came from AS_n may arm, otherwise a
         // cycle left running across reset would be picked up mid-way.
         sync_fill <= {sync_fill[0], 1'b1};
         if (sync_fill[1] && as_s) begin
            armed <= 1'b1;
         end
         if (start) begin
            addr_l <= ADDR;
            rw_l   <= RW;
            boot_l <= BOOT;
            wcnt   <= wait_of(rgn_start);
            tcnt   <= '0;
         end else begin
            if (state == ST_WAIT && wcnt != '0) begin
               wcnt <= wcnt - CNT_ONE;
            end
            // Timeout saturates at its last value so BERR_n holds steadily.
            if ((state == ST_WAIT || state == ST_BERR) && tcnt != TMO_LAST) begin
               tcnt <= tcnt + CNT_ONE;
            end
         end
      end
   end

   // State register; outputs are registered here too so the CPU sees glitch-free strobes.
   always_ff @(posedge CLK) begin
      if (!RESET_n) begin
         state    <= ST_IDLE;
         RAM_CS_n <= 1'b1;
         ROM_CS_n <= 1'b1;
         IO_CS_n  <= 1'b1;
         DTACK_n  <= 1'b1;
         BERR_n   <= 1'b1;
      end else begin
         state    <= state_nxt;
         RAM_CS_n <= ram_cs_nxt;
         ROM_CS_n <= rom_cs_nxt;
         IO_CS_n  <= io_cs_nxt;
         DTACK_n  <= dtack_nxt;
         BERR_n   <= berr_nxt;
      end
   end

   // Next-state logic; an AS_n release always wins and returns to IDLE.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: begin
            if (start) begin
               state_nxt = (rgn_start == RGN_NONE) ? ST_BERR : ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (as_s) begin
               state_nxt = ST_IDLE;
            end else if (wcnt == '0) begin
               state_nxt = ST_ACK;
            end else if (tcnt == TMO_LAST) begin
               // Wait states longer than the timeout: give up with a bus error.
               state_nxt = ST_BERR;
            end
         end
         ST_ACK: begin
            if (as_s) state_nxt = ST_IDLE;
         end
         ST_BERR: begin
            if (as_s) state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Output decode from the next state, so strobes change on the same edge as the state.
   always_comb begin
      rgn_nxt    = (state == ST_IDLE) ? rgn_start : rgn_cur;
      sel_nxt    = (state_nxt == ST_WAIT) || (state_nxt == ST_ACK);
      ram_cs_nxt = !(sel_nxt && rgn_nxt == RGN_RAM);
      rom_cs_nxt = !(sel_nxt && rgn_nxt == RGN_ROM);
      io_cs_nxt  = !(sel_nxt && rgn_nxt == RGN_IO);
      dtack_nxt  = !(state_nxt == ST_ACK);
      // Counter reached its last value on the previous edge; assert on this one.
      berr_nxt   = !((state == ST_BERR) && (state_nxt == ST_BERR) && (tcnt == TMO_LAST));
   end

endmodule

// File: tb/tb_bus_cycle_controller.sv
// Self-checking bench for bus_cycle_controller: vector table plus completion scoreboard.
// Latency: expectations are counted in clocks from the AS_n falling edge.
// Backpressure: each bus cycle is held until its DTACK_n/BERR_n completion is observed.
module tb_bus_cycle_controller;

   localparam int RAM_W = 1;
   localparam int ROM_W = 3;
   localparam int IO_W  = 4;
   localparam int TMO   = 64;
   // AS_n driven low on a falling edge reaches the FSM as a start on the 3rd rising edge.
   localparam int SYNC     = 3;
   localparam int LAT_RAM  = SYNC + RAM_W + 1;
   localparam int LAT_ROM  = SYNC + ROM_W + 1;
   localparam int LAT_IO   = SYNC + IO_W + 1;
   localparam int LAT_BERR = SYNC + TMO;
   localparam logic [2:0] M_NONE = 3'b000;
   localparam logic [2:0] M_RAM  = 3'b001;
   localparam logic [2:0] M_ROM  = 3'b010;
   localparam logic [2:0] M_IO   = 3'b100;

   logic       CLK = 1'b0;
   logic       RESET_n;
   logic       AS_n;
   logic       RW;
   logic [3:0] ADDR;
   logic       BOOT;
   logic       RAM_CS_n;
   logic       ROM_CS_n;
   logic       IO_CS_n;
   logic       DTACK_n;
   logic       BERR_n;

   always #5 CLK = ~CLK;

   bus_cycle_controller dut (
      .CLK      (CLK),
      .RESET_n  (RESET_n),
      .AS_n     (AS_n),
      .RW       (RW),
      .ADDR     (ADDR),
      .BOOT     (BOOT),
      .RAM_CS_n (RAM_CS_n),
      .ROM_CS_n (ROM_CS_n),
      .IO_CS_n  (IO_CS_n),
      .DTACK_n  (DTACK_n),
      .BERR_n   (BERR_n)
   );

   typedef struct {
      logic [2:0] mask;
      int         lat;
      logic       berr;
   } exp_t;

   typedef struct {
      logic       boot;
      logic       rw;
      logic [3:0] addr;
      logic [2:0] mask;
      int         lat;
      logic       berr;
   } vec_t;

   int   checks = 0;
   int   errors = 0;
   int   ev_cnt = 0;
   exp_t sb[$];
   vec_t vecs[12];

   task automatic chk(input string name, input int got, input int want);
      checks++;
      if (got != want) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, got, want);
      end
   endtask

   function automatic logic [2:0] cs_mask();
      return {~IO_CS_n, ~ROM_CS_n, ~RAM_CS_n};
   endfunction

   function automatic logic [4:0] all_out();
      return {RAM_CS_n, ROM_CS_n, IO_CS_n, DTACK_n, BERR_n};
   endfunction

   // Monitor: measures each cycle from AS_n falling and pops the scoreboard on completion.
   logic       as_prev = 1'b1;
   logic       dt_prev = 1'b1;
   logic       be_prev = 1'b1;
   int         cnt     = 0;
   logic [2:0] seen    = 3'b000;
   initial begin
      exp_t e;
      forever begin
         @(posedge CLK);
         #1;
         if (!AS_n) begin
            if (as_prev) begin
               cnt  = 1;
               seen = 3'b000;
            end else begin
               cnt++;
            end
            if (cnt >= SYNC) seen |= cs_mask();
         end
         as_prev = AS_n;
         if (RESET_n) begin
            chk("cs_at_most_one", int'($countones(cs_mask()) <= 1), 1);
            chk("dtack_berr_exclusive", int'(!DTACK_n && !BERR_n), 0);
         end
         if ((dt_prev && !DTACK_n) || (be_prev && !BERR_n)) begin
            if (sb.size() == 0) begin
               chk("unexpected_completion", 1, 0);
            end else begin
               e = sb.pop_front();
               chk("completion_is_berr", int'(!BERR_n), int'(e.berr));
               chk("completion_latency", cnt, e.lat);
               chk("cs_seen_in_cycle", int'(seen), int'(e.mask));
            end
            ev_cnt++;
         end
         dt_prev = DTACK_n;
         be_prev = BERR_n;
      end
   end

   // One bus cycle, called on a falling edge; returns on a falling edge.
   task automatic do_cycle(input string name, input logic boot, input logic rw,
                           input logic [3:0] addr, input logic [2:0] mask,
                           input int lat, input logic berr, input bit b2b, input bit flip);
      exp_t e;
      int   start_ev;
      bit   done;
      e.mask = mask;
      e.lat  = lat;
      e.berr = berr;
      BOOT   = boot;
      RW     = rw;
      ADDR   = addr;
      AS_n   = 1'b0;
      sb.push_back(e);
      start_ev = ev_cnt;
      done     = 1'b0;
      for (int i = 1; i <= lat + 20 && !done; i++) begin
         @(posedge CLK);
         #2;
         if (flip && i == 4) BOOT = ~boot;
         if (ev_cnt != start_ev) done = 1'b1;
      end
      if (!done) begin
         chk({name, "_timeout"}, 0, 1);
         sb.delete();
      end
      @(negedge CLK);
      AS_n = 1'b1;
      if (b2b) begin
         @(negedge CLK);
      end else begin
         @(posedge CLK);
         @(posedge CLK);
         #2;
         chk({name, "_held_until_release"}, int'(berr ? BERR_n : DTACK_n), 0);
         @(posedge CLK);
         #2;
         chk({name, "_released"}, int'(all_out()), 5'h1f);
         repeat (2) @(negedge CLK);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got running expected finished");
      $fatal(1, "watchdog");
   end

   initial begin
      //          boot  rw    addr   mask    lat       berr
      vecs[0]  = '{1'b0, 1'b1, 4'h0, M_ROM,  LAT_ROM,  1'b0};
      vecs[1]  = '{1'b1, 1'b1, 4'h0, M_RAM,  LAT_RAM,  1'b0};
      vecs[2]  = '{1'b1, 1'b0, 4'hE, M_IO,   LAT_IO,   1'b0};
      vecs[3]  = '{1'b1, 1'b1, 4'h8, M_NONE, LAT_BERR, 1'b1};
      vecs[4]  = '{1'b1, 1'b0, 4'hF, M_NONE, LAT_BERR, 1'b1};
      vecs[5]  = '{1'b1, 1'b1, 4'hF, M_ROM,  LAT_ROM,  1'b0};
      vecs[6]  = '{1'b1, 1'b0, 4'h1, M_RAM,  LAT_RAM,  1'b0};
      vecs[7]  = '{1'b0, 1'b0, 4'h0, M_RAM,  LAT_RAM,  1'b0};
      vecs[8]  = '{1'b0, 1'b0, 4'hF, M_NONE, LAT_BERR, 1'b1};
      vecs[9]  = '{1'b0, 1'b1, 4'h8, M_ROM,  LAT_ROM,  1'b0};
      vecs[10] = '{1'b1, 1'b1, 4'hE, M_IO,   LAT_IO,   1'b0};
      vecs[11] = '{1'b1, 1'b0, 4'hD, M_NONE, LAT_BERR, 1'b1};

      RESET_n = 1'b0;
      AS_n    = 1'b1;
      RW      = 1'b1;
      BOOT    = 1'b0;
      ADDR    = 4'h0;
      repeat (3) @(negedge CLK);
      chk("reset_ram_cs_n", int'(RAM_CS_n), 1);
      chk("reset_rom_cs_n", int'(ROM_CS_n), 1);
      chk("reset_io_cs_n",  int'(IO_CS_n),  1);
      chk("reset_dtack_n",  int'(DTACK_n),  1);
      chk("reset_berr_n",   int'(BERR_n),   1);
      RESET_n = 1'b1;
      repeat (4) @(negedge CLK);

      foreach (vecs[i]) begin
         do_cycle($sformatf("vec%0d", i), vecs[i].boot, vecs[i].rw, vecs[i].addr,
                  vecs[i].mask, vecs[i].lat, vecs[i].berr, 1'b0, 1'b0);
      end

      // Back-to-back reads separated by a single clock of AS_n high.
      do_cycle("b2b_first",  1'b1, 1'b1, 4'h0, M_RAM, LAT_RAM, 1'b0, 1'b1, 1'b0);
      do_cycle("b2b_second", 1'b1, 1'b1, 4'hF, M_ROM, LAT_ROM, 1'b0, 1'b0, 1'b0);

      // BOOT rising mid-cycle must not move a boot-time read away from ROM.
      do_cycle("boot_flip", 1'b0, 1'b1, 4'h0, M_ROM, LAT_ROM, 1'b0, 1'b0, 1'b1);

      // Reset during WAIT with AS_n held low, then no restart until AS_n toggles.
      BOOT = 1'b1;
      RW   = 1'b0;
      ADDR = 4'hE;
      AS_n = 1'b0;
      repeat (5) @(posedge CLK);
      #2;
      chk("io_cs_before_reset", int'(IO_CS_n), 0);
      @(negedge CLK);
      RESET_n = 1'b0;
      @(posedge CLK);
      #2;
      chk("reset_midcycle_outputs", int'(all_out()), 5'h1f);
      @(negedge CLK);
      RESET_n = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(posedge CLK);
         #2;
         chk("no_start_after_reset", int'(all_out()), 5'h1f);
      end
      @(negedge CLK);
      AS_n = 1'b1;
      repeat (4) @(negedge CLK);
      do_cycle("after_reset", 1'b1, 1'b0, 4'hE, M_IO, LAT_IO, 1'b0, 1'b0, 1'b0);

      chk("scoreboard_empty", sb.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
